// File: rtl/icache_fetch.sv
// Direct-mapped, one-word-per-line instruction cache for the fetch port.
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
`ifndef RW
`define RW 16
`endif
`ifndef I_SIZE
`define I_SIZE 32
`endif

module icache_fetch #(
    parameter int INDEX_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [`RW-1:0]    i_req_addr,
    input  logic              i_req_ppl_submit,
    input  logic              i_instr_page,
    input  logic              i_flush,
    output logic [`I_SIZE-1:0] o_req_data,
    output logic              o_req_data_valid,
    output logic              o_mem_req,
    output logic [`RW-1:0]    o_mem_addr,
    input  logic [`I_SIZE-1:0] i_mem_data,
    input  logic              i_mem_ack
`ifdef ICACHE_STATS_EN
    ,
    output logic [`RW-1:0]    o_hit_cnt,
    output logic [`RW-1:0]    o_miss_cnt
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = `RW - INDEX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_FILL
    } state_t;

    state_t state_q, state_d;

    logic [`RW-1:0]      req_addr_q;
    logic                req_page_q;
    logic                fill_page_q;
    logic                pend_q;
    logic                no_alloc_q;
    logic [`I_SIZE-1:0]  resp_q;
    logic                resp_valid_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_arr [LINES];
    logic [`I_SIZE-1:0]  data_arr [LINES];

    logic [INDEX_W-1:0]  idx;
    logic [INDEX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]    tag;
    logic [TAG_W-1:0]    fill_tag;
    logic                hit;
    logic                lookup_hit;
    logic                lookup_miss;
    logic                fill_ack;

    assign idx      = req_addr_q[INDEX_W-1:0];
    assign tag      = {req_page_q, req_addr_q[`RW-1:INDEX_W]};
    assign fill_idx = o_mem_addr[INDEX_W-1:0];
    assign fill_tag = {fill_page_q, o_mem_addr[`RW-1:INDEX_W]};
    assign hit      = valid_q[idx] && (tag_arr[idx] == tag);
    assign fill_ack = (state_q == S_FILL) && i_mem_ack;

    always_comb begin
        state_d     = state_q;
        lookup_hit  = 1'b0;
        lookup_miss = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_req_ppl_submit) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit) begin
                    lookup_hit = 1'b1;
                    state_d    = i_req_ppl_submit ? S_LOOKUP : S_IDLE;
                end else begin
                    lookup_miss = 1'b1;
                    state_d     = S_FILL;
                end
            end
            S_FILL: begin
                if (i_mem_ack)
                    state_d = (pend_q || i_req_ppl_submit) ? S_LOOKUP : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_req_data       = lookup_hit ? data_arr[idx] : resp_q;
    assign o_req_data_valid = lookup_hit || resp_valid_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= S_IDLE;
            req_addr_q   <= '0;
            req_page_q   <= 1'b0;
            fill_page_q  <= 1'b0;
            pend_q       <= 1'b0;
            no_alloc_q   <= 1'b0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            o_mem_req    <= 1'b0;
            o_mem_addr   <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= 1'b0;
            if (i_req_ppl_submit) begin
                req_addr_q <= i_req_addr;
                req_page_q <= i_instr_page;
            end
            if (lookup_miss) begin
                o_mem_req   <= 1'b1;
                o_mem_addr  <= req_addr_q;
                fill_page_q <= req_page_q;
                pend_q      <= i_req_ppl_submit;
                no_alloc_q  <= i_flush;
            end
            if (state_q == S_FILL) begin
                if (i_req_ppl_submit) pend_q <= 1'b1;
                if (i_flush) no_alloc_q <= 1'b1;
                if (i_mem_ack) begin
                    o_mem_req    <= 1'b0;
                    resp_q       <= i_mem_data;
                    // a redirect makes this fill's answer stale for fetch
                    resp_valid_q <= !(pend_q || i_req_ppl_submit);
                    pend_q       <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            valid_q <= '0;
        end else if (i_flush) begin
            valid_q <= '0;
        end else if (fill_ack && !no_alloc_q) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (fill_ack) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= i_mem_data;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
        end else begin
            if (lookup_hit && (o_hit_cnt != '1))
                o_hit_cnt <= o_hit_cnt + 1'b1;
            if (lookup_miss && (o_miss_cnt != '1))
                o_miss_cnt <= o_miss_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Randomized bench for icache_fetch against a line-level cache model.
// Memory responder and model live here; all checks go through check().
module tb_icache_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] i_req_addr = '0;
    logic        i_req_ppl_submit = 1'b0;
    logic        i_instr_page = 1'b0;
    logic        i_flush = 1'b0;
    logic [31:0] o_req_data;
    logic        o_req_data_valid;
    logic        o_mem_req;
    logic [15:0] o_mem_addr;
    logic [31:0] i_mem_data = '0;
    logic        i_mem_ack = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [15:0] o_hit_cnt;
    logic [15:0] o_miss_cnt;
`endif

    icache_fetch dut (
        .i_clk            (clk),
        .i_rst            (rst_n),
        .i_req_addr       (i_req_addr),
        .i_req_ppl_submit (i_req_ppl_submit),
        .i_instr_page     (i_instr_page),
        .i_flush          (i_flush),
        .o_req_data       (o_req_data),
        .o_req_data_valid (o_req_data_valid),
        .o_mem_req        (o_mem_req),
        .o_mem_addr       (o_mem_addr),
        .i_mem_data       (i_mem_data),
        .i_mem_ack        (i_mem_ack)
`ifdef ICACHE_STATS_EN
        ,
        .o_hit_cnt        (o_hit_cnt),
        .o_miss_cnt       (o_miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model: per line, the full address/page it holds and the word
    bit          mv [16];
    logic [15:0] ma [16];
    bit          mp [16];
    logic [31:0] md [16];
    int          exp_hits = 0;
    int          exp_misses = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic bit m_hit(input logic [15:0] a, input bit p);
        int i;
        i = int'(a % 16);
        return mv[i] && (ma[i] == a) && (mp[i] == p);
    endfunction

    task automatic m_flush;
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endtask

    task automatic lookup_phase(input logic [15:0] a, input bit p,
                                output bit miss);
        bit h;
        h = m_hit(a, p);
        check("lk_vld", 32'(o_req_data_valid), 32'(h));
        check("lk_memreq", 32'(o_mem_req), 32'd0);
        if (h) begin
            check("hit_data", o_req_data, md[int'(a % 16)]);
            exp_hits++;
            tick;
            check("hit_once", 32'(o_req_data_valid), 32'd0);
        end else begin
            exp_misses++;
        end
        miss = !h;
    endtask

    task automatic fill_phase(input logic [15:0] a, input bit p,
                              input int lat, input logic [31:0] d,
                              input bit fl, input bit rd,
                              input logic [15:0] ra, input bit rp);
        bit flushed;
        flushed = 1'b0;
        tick;
        for (int c = 0; c < lat; c++) begin
            check("fill_req", 32'(o_mem_req), 32'd1);
            check("fill_addr", 32'(o_mem_addr), 32'(a));
            check("fill_vld", 32'(o_req_data_valid), 32'd0);
            if (rd && c == 0) begin
                i_req_addr = ra;
                i_instr_page = rp;
                i_req_ppl_submit = 1'b1;
            end
            if (fl && c == 0) begin
                i_flush = 1'b1;
                flushed = 1'b1;
                m_flush();
            end
            tick;
            i_req_ppl_submit = 1'b0;
            i_flush = 1'b0;
        end
        check("ack_req", 32'(o_mem_req), 32'd1);
        check("ack_addr", 32'(o_mem_addr), 32'(a));
        i_mem_ack = 1'b1;
        i_mem_data = d;
        tick;
        i_mem_ack = 1'b0;
        i_mem_data = $urandom;
        if (!flushed) begin
            mv[int'(a % 16)] = 1'b1;
            ma[int'(a % 16)] = a;
            mp[int'(a % 16)] = p;
            md[int'(a % 16)] = d;
        end
        check("req_drop", 32'(o_mem_req), 32'd0);
        if (!rd) begin
            check("fill_rsp_vld", 32'(o_req_data_valid), 32'd1);
            check("fill_rsp_data", o_req_data, d);
            tick;
            check("fill_rsp_once", 32'(o_req_data_valid), 32'd0);
        end
    endtask

    task automatic fetch(input logic [15:0] a, input bit p, input int lat,
                         input logic [31:0] d, input bit fl, input bit rd,
                         input logic [15:0] ra, input bit rp,
                         input logic [31:0] rdata);
        bit miss;
        i_req_addr = a;
        i_instr_page = p;
        i_req_ppl_submit = 1'b1;
        tick;
        i_req_ppl_submit = 1'b0;
        i_req_addr = 16'($urandom);
        lookup_phase(a, p, miss);
        if (miss) begin
            fill_phase(a, p, lat, d, fl, rd, ra, rp);
            if (rd) begin
                lookup_phase(ra, rp, miss);
                if (miss) fill_phase(ra, rp, 1, rdata, 1'b0, 1'b0, '0, 1'b0);
            end
        end
    endtask

    task automatic do_flush;
        i_flush = 1'b1;
        tick;
        i_flush = 1'b0;
        m_flush();
    endtask

    task automatic burst;
        int k;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (mv[i]) begin
                i_req_addr = ma[i];
                i_instr_page = mp[i];
                i_req_ppl_submit = 1'b1;
                tick;
                check("b2b_vld", 32'(o_req_data_valid), 32'd1);
                check("b2b_data", o_req_data, md[i]);
                exp_hits++;
                k++;
            end
        end
        i_req_ppl_submit = 1'b0;
        if (k > 0) begin
            tick;
            check("b2b_end", 32'(o_req_data_valid), 32'd0);
        end
    endtask

    task automatic check_stats;
`ifdef ICACHE_STATS_EN
        check("hit_cnt", 32'(o_hit_cnt), 32'(exp_hits));
        check("miss_cnt", 32'(o_miss_cnt), 32'(exp_misses));
`endif
    endtask

    initial begin
        logic [15:0] a, ra;
        bit p, rp, fl, rd;
        int lat;
        m_flush();
        tick;
        check("rst_vld", 32'(o_req_data_valid), 32'd0);
        check("rst_data", o_req_data, 32'd0);
        check("rst_req", 32'(o_mem_req), 32'd0);
        check("rst_addr", 32'(o_mem_addr), 32'd0);
        tick;
        rst_n = 1'b1;
        tick;

        fetch(16'h0010, 1'b0, 3, 32'hDEAD_BEEF, 0, 0, '0, 0, '0);
        fetch(16'h0010, 1'b0, 3, 32'h1111_1111, 0, 0, '0, 0, '0);
        fetch(16'h0020, 1'b0, 2, 32'hA0A0_0020, 0, 0, '0, 0, '0);
        fetch(16'h0010, 1'b1, 1, 32'hB1B1_0010, 0, 0, '0, 0, '0);
        fetch(16'h0020, 1'b0, 0, 32'hC2C2_0020, 0, 0, '0, 0, '0);
        fetch(16'h0015, 1'b0, 1, 32'h0000_0015, 0, 0, '0, 0, '0);
        do_flush();
        fetch(16'h0015, 1'b0, 2, 32'h5555_0015, 0, 0, '0, 0, '0);
        fetch(16'h0053, 1'b0, 2, 32'h5353_5353, 1, 0, '0, 0, '0);
        fetch(16'h0053, 1'b0, 1, 32'h5454_5454, 0, 0, '0, 0, '0);
        fetch(16'h0053, 1'b0, 1, 32'h0, 0, 0, '0, 0, '0);
        fetch(16'h0030, 1'b0, 2, 32'h3030_3030, 0, 1, 16'h0047, 0,
              32'h4747_4747);
        fetch(16'h0047, 1'b0, 1, 32'h0, 0, 0, '0, 0, '0);
        check_stats();

        // reset while a fill is outstanding
        i_req_addr = 16'h0061;
        i_instr_page = 1'b0;
        i_req_ppl_submit = 1'b1;
        tick;
        i_req_ppl_submit = 1'b0;
        tick;
        check("pre_rst_req", 32'(o_mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_fill_req", 32'(o_mem_req), 32'd0);
        tick;
        rst_n = 1'b1;
        m_flush();
        exp_hits = 0;
        exp_misses = 0;
        i_mem_ack = 1'b1;
        i_mem_data = 32'h6161_6161;
        tick;
        i_mem_ack = 1'b0;
        check("late_ack_vld", 32'(o_req_data_valid), 32'd0);
        check("late_ack_req", 32'(o_mem_req), 32'd0);
        tick;
        check("late_ack_vld2", 32'(o_req_data_valid), 32'd0);
        fetch(16'h0047, 1'b0, 1, 32'h7777_0047, 0, 0, '0, 0, '0);
        fetch(16'h0015, 1'b0, 1, 32'h7777_0015, 0, 0, '0, 0, '0);
        burst();

        p = 1'b0;
        for (int n = 0; n < 200; n++) begin
            a = 16'($urandom_range(0, 47));
            if ($urandom_range(0, 7) == 0) p = !p;
            lat = $urandom_range(0, 4);
            fl = (lat > 0) && ($urandom_range(0, 7) == 0);
            rd = (lat > 0) && ($urandom_range(0, 5) == 0);
            ra = 16'($urandom_range(0, 47));
            rp = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 11) == 0) do_flush();
            if ($urandom_range(0, 9) == 0) burst();
            fetch(a, p, lat, $urandom, fl, rd, ra, rp, $urandom);
        end
        burst();
        check_stats();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
